// File: rtl/stego_pkg.sv
// stego_pkg: shared types and constants for the steganography extraction path.
// Rev 1.0
`default_nettype none

package stego_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_EMIT    = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam int                CHAR_W    = 8;
    localparam logic [CHAR_W-1:0] CHAR_TERM = 8'h00;

endpackage

`default_nettype wire

// File: rtl/lsb_shift_assembler.sv
// lsb_shift_assembler: MSB-first bit collector; outputs show the value after the current edge.
// Rev 1.0
`default_nettype none

module lsb_shift_assembler
    import stego_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              shift_en_i,
    input  logic              bit_in_i,
    output logic [CHAR_W-1:0] byte_out_o,
    output logic              full_o
);

    logic [CHAR_W-1:0] shreg_q, shreg_d;
    logic [2:0]        cnt_q, cnt_d;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (clr_i) begin
            shreg_d = '0;
            cnt_d   = 3'd0;
        end else if (shift_en_i) begin
            shreg_d = {shreg_q[CHAR_W-2:0], bit_in_i};
            cnt_d   = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= 3'd0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Look-ahead so the controller can decide on the completed byte in the capture cycle.
    assign byte_out_o = shreg_d;
    assign full_o     = shift_en_i && !clr_i && (cnt_q == 3'd7);

endmodule

`default_nettype wire

// File: rtl/stego_extract_ctrl.sv
// stego_extract_ctrl: walks image memory, assembles LSBs into characters, streams them out.
// Rev 1.0
`default_nettype none

module stego_extract_ctrl
    import stego_pkg::*;
#(
    parameter int IMG_W    = 4,
    parameter int IMG_H    = 4,
    parameter int CHANNELS = 3,
    parameter int MAX_MSG  = 64,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [CHAR_W-1:0] mem_data_i,
    output logic [CHAR_W-1:0] char_data_o,
    output logic              char_valid_o,
    input  logic              char_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              truncated_o,
    output logic [7:0]        msg_len_o
);

    localparam int                TOTAL     = IMG_W * IMG_H * CHANNELS;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
    localparam logic [7:0]        MSG_LIMIT = 8'(MAX_MSG);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        msg_len_q, msg_len_d;
    logic              trunc_q, trunc_d;
    logic              exhaust_q, exhaust_d;

    logic              w_clr, w_shift, w_full;
    logic [CHAR_W-1:0] w_byte;
    logic              w_unused_bits;

    assign w_unused_bits = ^mem_data_i[CHAR_W-1:1];

    lsb_shift_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (w_clr),
        .shift_en_i (w_shift),
        .bit_in_i   (mem_data_i[0]),
        .byte_out_o (w_byte),
        .full_o     (w_full)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        msg_len_d = msg_len_q;
        trunc_d   = trunc_q;
        exhaust_d = exhaust_q;
        w_clr     = 1'b0;
        w_shift   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    w_clr     = 1'b1;
                    msg_len_d = 8'd0;
                    trunc_d   = 1'b0;
                    exhaust_d = 1'b0;
                    addr_d    = '0;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                w_shift = 1'b1;
                addr_d  = addr_q + 1'b1;
                if (addr_q == LAST_ADDR) exhaust_d = 1'b1;
                // A byte completed on the last image byte still wins over truncation.
                if (w_full) begin
                    state_d = (w_byte == CHAR_TERM) ? ST_DONE : ST_EMIT;
                end else if (addr_q == LAST_ADDR) begin
                    trunc_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EMIT: begin
                if (char_ready_i) begin
                    msg_len_d = msg_len_q + 8'd1;
                    state_d   = ((msg_len_q + 8'd1) == MSG_LIMIT || exhaust_q) ? ST_DONE
                                                                            : ST_FETCH;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            msg_len_q <= 8'd0;
            trunc_q   <= 1'b0;
            exhaust_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            msg_len_q <= msg_len_d;
            trunc_q   <= trunc_d;
            exhaust_q <= exhaust_d;
        end
    end

    assign mem_rd_o     = (state_q == ST_FETCH);
    assign mem_addr_o   = mem_rd_o ? addr_q : '0;
    assign char_valid_o = (state_q == ST_EMIT);
    assign char_data_o  = char_valid_o ? w_byte : '0;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_DONE);
    assign truncated_o  = trunc_q;
    assign msg_len_o    = msg_len_q;

endmodule

`default_nettype wire

// File: tb/tb_stego_extract_ctrl.sv
// tb_stego_extract_ctrl: directed bench over three parameterisations of the extractor.
// Rev 1.0
`default_nettype none

module tb_stego_extract_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start[3], mem_rd[3], char_valid[3], char_ready[3];
    logic        busy[3], done[3], truncated[3];
    logic [15:0] mem_addr[3];
    logic [7:0]  mem_data[3], char_data[3], msg_len[3];
    logic [7:0]  mem[3][48];

    int exp_addr[3];
    bit addr_err[3], dbl_err[3], prev_rd[3];

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] got_ch[8];
    int         n_got;

    stego_extract_ctrl #(.IMG_W(4), .IMG_H(4), .CHANNELS(3), .MAX_MSG(64), .ADDR_W(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start[0]), .mem_rd_o(mem_rd[0]),
        .mem_addr_o(mem_addr[0]), .mem_data_i(mem_data[0]), .char_data_o(char_data[0]),
        .char_valid_o(char_valid[0]), .char_ready_i(char_ready[0]), .busy_o(busy[0]),
        .done_o(done[0]), .truncated_o(truncated[0]), .msg_len_o(msg_len[0]));

    stego_extract_ctrl #(.IMG_W(3), .IMG_H(3), .CHANNELS(3), .MAX_MSG(64), .ADDR_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start[1]), .mem_rd_o(mem_rd[1]),
        .mem_addr_o(mem_addr[1]), .mem_data_i(mem_data[1]), .char_data_o(char_data[1]),
        .char_valid_o(char_valid[1]), .char_ready_i(char_ready[1]), .busy_o(busy[1]),
        .done_o(done[1]), .truncated_o(truncated[1]), .msg_len_o(msg_len[1]));

    stego_extract_ctrl #(.IMG_W(4), .IMG_H(4), .CHANNELS(3), .MAX_MSG(2), .ADDR_W(16)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start_i(start[2]), .mem_rd_o(mem_rd[2]),
        .mem_addr_o(mem_addr[2]), .mem_data_i(mem_data[2]), .char_data_o(char_data[2]),
        .char_valid_o(char_valid[2]), .char_ready_i(char_ready[2]), .busy_o(busy[2]),
        .done_o(done[2]), .truncated_o(truncated[2]), .msg_len_o(msg_len[2]));

    // Image memory with one-cycle read latency; also tracks address order and strobe spacing.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (start[k] && !busy[k]) begin
                exp_addr[k] <= 0;
                addr_err[k] <= 1'b0;
                dbl_err[k]  <= 1'b0;
            end
            if (mem_rd[k]) begin
                mem_data[k] <= mem[k][mem_addr[k][5:0]];
                if (int'(mem_addr[k]) != exp_addr[k]) addr_err[k] <= 1'b1;
                exp_addr[k] <= exp_addr[k] + 1;
            end
            if (mem_rd[k] && prev_rd[k]) dbl_err[k] <= 1'b1;
            prev_rd[k] <= mem_rd[k];
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic load(input int k, input string s, input bit ones);
        logic       b;
        logic [7:0] c;
        for (int i = 0; i < 48; i++) begin
            if (ones) b = 1'b1;
            else if (i / 8 < s.len()) begin
                c = s[i / 8];
                b = c[7 - (i % 8)];
            end else b = 1'b0;
            mem[k][i] = {7'($urandom), b};
        end
    endtask

    task automatic run(input int k, input string tag, input int bp, input bit glitch,
                       input string exp_s, input int exp_len, input bit exp_tr,
                       input int exp_reads, input int exp_first);
        int         first, wait_n;
        bit         seen_done;
        logic [7:0] held, c;
        n_got = 0; first = -1; wait_n = 0; seen_done = 0; held = 8'h00;
        char_ready[k] = 1'b1;
        @(negedge clk) start[k] = 1'b1;
        @(negedge clk) start[k] = 1'b0;
        for (int cyc = 1; cyc < 1000; cyc++) begin
            start[k] = glitch && (cyc == 20);
            if (done[k]) begin
                seen_done = 1'b1;
                break;
            end
            if (char_valid[k]) begin
                if (first < 0) first = cyc;
                if (wait_n == 0) held = char_data[k];
                else chk({tag, "_hold"}, char_data[k], held);
                if (wait_n < bp) begin
                    char_ready[k] = 1'b0;
                    wait_n++;
                end else begin
                    char_ready[k] = 1'b1;
                    if (n_got < 8) got_ch[n_got] = char_data[k];
                    n_got++;
                    wait_n = 0;
                end
            end else char_ready[k] = 1'b1;
            @(negedge clk);
        end
        start[k] = 1'b0;
        chk({tag, "_done_seen"}, seen_done, 1);
        chk({tag, "_nchars"}, n_got, exp_s.len());
        for (int i = 0; i < exp_s.len() && i < n_got; i++) begin
            c = exp_s[i];
            chk($sformatf("%s_char%0d", tag, i), got_ch[i], c);
        end
        chk({tag, "_msg_len"}, msg_len[k], exp_len);
        chk({tag, "_truncated"}, truncated[k], exp_tr);
        if (exp_first > 0) chk({tag, "_first_valid_cyc"}, first, exp_first);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done[k], 0);
        chk({tag, "_idle"}, busy[k], 0);
        chk({tag, "_len_hold"}, msg_len[k], exp_len);
        chk({tag, "_addr_seq_err"}, addr_err[k], 0);
        chk({tag, "_rd_back2back"}, dbl_err[k], 0);
        chk({tag, "_reads"}, exp_addr[k], exp_reads);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit any_v;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0;
            char_ready[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", busy[0], 0);
        chk("rst_mem_rd", mem_rd[0], 0);
        chk("rst_valid", char_valid[0], 0);
        chk("rst_data", char_data[0], 0);
        chk("rst_done", done[0], 0);
        chk("rst_trunc", truncated[0], 0);
        chk("rst_len", msg_len[0], 0);
        chk("rst_addr", mem_addr[0], 0);
        rst_n = 1'b1;
        @(negedge clk);

        load(0, "Hi", 1'b0);
        run(0, "basic", 0, 1'b0, "Hi", 2, 1'b0, 24, 17);
        run(0, "bp", 5, 1'b1, "Hi", 2, 1'b0, 24, 17);

        load(0, "", 1'b1);
        run(0, "noterm", 0, 1'b0, "\377\377\377\377\377\377", 6, 1'b0, 48, 17);

        load(1, "", 1'b1);
        run(1, "trunc", 0, 1'b0, "\377\377\377", 3, 1'b1, 27, 17);

        load(2, "ABCDE", 1'b0);
        run(2, "limit", 0, 1'b0, "AB", 2, 1'b0, 16, 17);

        // Reset while a character is waiting in EMIT.
        load(0, "Hi", 1'b0);
        char_ready[0] = 1'b0;
        @(negedge clk) start[0] = 1'b1;
        @(negedge clk) start[0] = 1'b0;
        for (int i = 0; i < 100 && !char_valid[0]; i++) @(negedge clk);
        chk("rstemit_reached", char_valid[0], 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstemit_valid", char_valid[0], 0);
        chk("rstemit_data", char_data[0], 0);
        chk("rstemit_busy", busy[0], 0);
        chk("rstemit_len", msg_len[0], 0);
        @(negedge clk) rst_n = 1'b1;
        char_ready[0] = 1'b1;
        any_v = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (char_valid[0] || busy[0]) any_v = 1'b1;
        end
        chk("rstemit_no_char", any_v, 0);

        run(0, "after_rst", 0, 1'b0, "Hi", 2, 1'b0, 24, 17);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
